// File: rtl/sbox_32_pkg.sv
// Shared cipher constants: 4-bit S-box tables, word geometry, round constants.
// The round-constant table and round count belong to the cipher controller.
`default_nettype none

package sbox_32_pkg;

  localparam int WORD_W  = 32;
  localparam int NIBBLES = 8;
  localparam int NIB_W   = 4;
  localparam int ROUNDS  = 12;

  // Entry n sits in nibble n, so each table reads right-to-left from input 0.
  localparam logic [15:0][3:0] SBOX_FWD = 64'h2174_8FE3_DA09_B65C;
  localparam logic [15:0][3:0] SBOX_INV = 64'hA970_364B_D21C_8FE5;

  localparam logic [ROUNDS-1:0][7:0] ROUND_CONST = 96'h2F_5E_BC_63_C6_97_35_6A_D4_B3_7D_FA;

  function automatic logic [NIB_W-1:0] sbox_lookup(input logic [NIB_W-1:0] nib,
                                                   input logic             inv_sel);
    return inv_sel ? SBOX_INV[nib] : SBOX_FWD[nib];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sbox_32_sbox4.sv
// Combinational 4-bit S-box lookup with forward/inverse select.
`default_nettype none

module sbox_32_sbox4
  import sbox_32_pkg::*;
(
  input  logic [NIB_W-1:0] nib_in,
  input  logic             inv,
  output logic [NIB_W-1:0] nib_out
);

  assign nib_out = sbox_lookup(nib_in, inv);

endmodule

`default_nettype wire

// File: rtl/sbox_32.sv
// 32-bit nibble-wise substitution layer: eight parallel S-boxes, one registered stage.
`default_nettype none

module sbox_32
  import sbox_32_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] inText,
  input  logic              inv,
  input  logic              in_valid,
  output logic [WORD_W-1:0] outText,
  output logic              out_valid
);

  logic [WORD_W-1:0] sub_word;

  generate
    for (genvar i = 0; i < NIBBLES; i++) begin : g_nib
      sbox_32_sbox4 u_sbox4 (
        .nib_in  (inText[NIB_W*i +: NIB_W]),
        .inv     (inv),
        .nib_out (sub_word[NIB_W*i +: NIB_W])
      );
    end
  endgenerate

  // outText only loads on accepted words, so idle-cycle X never reaches it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outText   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        outText <= sub_word;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sbox_32.sv
// Scoreboard bench for sbox_32: expected words queued at drive time, popped on out_valid.
`default_nettype none

module tb_sbox_32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inText;
  logic        inv;
  logic        in_valid;
  logic [31:0] outText;
  logic        out_valid;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] sb[$];
  logic [31:0] mon_exp;

  logic [3:0] fwd_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [3:0] inv_t [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                             4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

  always #5 clk = ~clk;

  sbox_32 dut (
    .clk       (clk),
    .reset     (reset),
    .inText    (inText),
    .inv       (inv),
    .in_valid  (in_valid),
    .outText   (outText),
    .out_valid (out_valid)
  );

  function automatic logic [31:0] model(input logic [31:0] d, input logic i);
    logic [31:0] r;
    for (int n = 0; n < 8; n++)
      r[4*n +: 4] = i ? inv_t[d[4*n +: 4]] : fwd_t[d[4*n +: 4]];
    return r;
  endfunction

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected_valid outText=%h expected no output", outText);
      end else begin
        mon_exp = sb.pop_front();
        if (outText !== mon_exp)
          $display("FAIL sb_word outText=%h expected=%h", outText, mon_exp);
        else
          passes++;
      end
    end
  end

  // Called at a falling edge; returns at the next falling edge.
  task automatic send(input logic [31:0] d, input logic i, input logic [31:0] exp);
    in_valid = 1'b1;
    inText   = d;
    inv      = i;
    sb.push_back(exp);
    @(negedge clk);
  endtask

  task automatic idle_drain(input int n);
    in_valid = 1'b0;
    inText   = 'x;
    inv      = 1'b0;
    repeat (n) @(negedge clk);
    checks++;
    if (sb.size() != 0) $display("FAIL sb_drain pending=%0d expected 0", sb.size());
    else passes++;
    sb.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; inText = '0; inv = 1'b0;
    #2;
    checks++;
    if (outText !== 32'h0) $display("FAIL rst_outText got=%h expected=00000000", outText);
    else passes++;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b expected=0", out_valid);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_forward;
    send(32'h0123_4567, 1'b0, 32'hC56B_90AD);
    send(32'h89AB_CDEF, 1'b0, 32'h3EF8_4712);
    send(32'h0000_0000, 1'b0, 32'hCCCC_CCCC);
    send(32'hFFFF_FFFF, 1'b0, 32'h2222_2222);
    idle_drain(2);
  endtask

  task automatic test_inverse;
    send(32'hC56B_90AD, 1'b1, 32'h0123_4567);
    send(32'h3EF8_4712, 1'b1, 32'h89AB_CDEF);
    idle_drain(2);
  endtask

  task automatic test_back_to_back;
    send(32'h0123_4567, 1'b0, 32'hC56B_90AD);
    send(32'h3EF8_4712, 1'b1, 32'h89AB_CDEF);
    send(32'hFFFF_FFFF, 1'b0, 32'h2222_2222);
    // Monitor consumed the third word at this edge; now drop in_valid with X data.
    in_valid = 1'b0;
    inText   = 'x;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) $display("FAIL hold_valid got=%b expected=0", out_valid);
      else passes++;
      checks++;
      if (outText !== 32'h2222_2222) $display("FAIL hold_outText got=%h expected=22222222", outText);
      else passes++;
    end
    idle_drain(1);
  endtask

  task automatic test_reset_midop;
    in_valid = 1'b1; inText = 32'h89AB_CDEF; inv = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b1) $display("FAIL midop_pre_valid got=%b expected=1", out_valid);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if (outText !== 32'h0) $display("FAIL midop_rst_outText got=%h expected=00000000", outText);
    else passes++;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL midop_rst_valid got=%b expected=0", out_valid);
    else passes++;
    inText = 32'h0123_4567;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL midop_held_valid got=%b expected=0", out_valid);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(32'hC56B_90AD);
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL midop_release_valid got=%b expected=0", out_valid);
    else passes++;
    @(negedge clk);
    idle_drain(2);
  endtask

  task automatic test_random;
    logic [31:0] x;
    logic [31:0] y;
    for (int k = 0; k < 10000; k++) begin
      x = $urandom;
      send(x, 1'b1, model(x, 1'b1));
      y = outText;
      send(y, 1'b0, x);
    end
    idle_drain(2);
  endtask

  initial begin
    test_reset;
    test_forward;
    test_inverse;
    test_back_to_back;
    test_reset_midop;
    test_random;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
